// File: rtl/gmii_rx_deframer_pkg.sv
// Shared constants and types for the GMII receive deframer.
// Covers the preamble/SFD bytes, the byte-tag (PCC) codes and the CRC-32 constants.
package gmii_rx_deframer_pkg;

  localparam logic [7:0]  GMII_PRE      = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;

  localparam logic [1:0]  PCC_DATA      = 2'd0;
  localparam logic [1:0]  PCC_SOP       = 2'd1;
  localparam logic [1:0]  PCC_EOP       = 2'd2;
  localparam logic [1:0]  PCC_BADEOP    = 2'd3;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] data;
  } pcc_beat_t;

endpackage

// File: rtl/gmii_rx_fifo.sv
// Synchronous FIFO of tagged bytes between the GMII deframer and the parser.
// The write side never checks for full; the parent reserves space before writing.
module gmii_rx_fifo
  import gmii_rx_deframer_pkg::*;
#(
  parameter int ASZ = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            wr_en_i,
  input  pcc_beat_t       wr_data_i,
  output logic            rd_srdy_o,
  input  logic            rd_drdy_i,
  output pcc_beat_t       rd_data_o,
  output logic [ASZ:0]    count_o
);

  localparam int DEPTH = 1 << ASZ;

  pcc_beat_t          mem_q [DEPTH];
  logic [ASZ-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ASZ-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ASZ:0]       count_q, count_d;
  logic               rd_fire;

  assign rd_srdy_o = (count_q != '0);
  assign rd_fire   = rd_srdy_o & rd_drdy_i;
  assign rd_data_o = rd_srdy_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en_i, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data-only; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive front end: strips preamble/SFD, checks FCS and length, and
// buffers each frame as a SOP/DATA/EOP/BADEOP tagged byte stream.
module gmii_rx_deframer
  import gmii_rx_deframer_pkg::*;
#(
  parameter int ASZ     = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  output logic       rxg_srdy,
  input  logic       rxg_drdy,
  output logic [7:0] rxg_data,
  output logic [1:0] rxg_code,
  output logic       stat_good,
  output logic       stat_bad,
  output logic       stat_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [ASZ:0] CNT_DEPTH = {1'b1, {ASZ{1'b0}}};
  localparam logic [ASZ:0] CNT_SOFT  = {1'b0, {ASZ{1'b1}}};
  localparam logic [15:0]  LEN_MIN   = 16'(MIN_LEN);
  localparam logic [15:0]  LEN_MAX   = 16'(MAX_LEN);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] r;
    r = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic [7:0]  rxd_q;
  logic        dv_q, dv_p_q;
  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ovr_q, ovr_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic        drop_q, drop_d;

  logic         wr_en;
  pcc_beat_t    wr_data;
  pcc_beat_t    rd_data;
  logic [ASZ:0] fifo_count;
  logic         frame_ok;

  assign frame_ok = (crc_q == CRC32_RESIDUE) && (len_q >= LEN_MIN) &&
                    (len_q <= LEN_MAX) && !ovr_q;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ovr_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (dv_q && !dv_p_q) begin
          if (rxd_q == GMII_PRE)      state_d = S_PRE;
          else if (rxd_q == GMII_SFD) state_d = S_DATA;
          else                        state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!dv_q) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
        end else if (rxd_q == GMII_SFD) begin
          state_d = S_DATA;
        end else if (rxd_q != GMII_PRE) begin
          state_d = S_DROP;
          drop_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (dv_q) begin
          crc_d      = crc32_byte(crc_q, rxd_q);
          len_d      = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          pend_d     = rxd_q;
          pend_vld_d = 1'b1;
          // The byte leaving pending is byte 0 exactly when one byte has been counted.
          if (pend_vld_q && !ovr_q) begin
            if (fifo_count < CNT_SOFT) begin
              wr_en   = 1'b1;
              wr_data = '{code: (len_q == 16'd1) ? PCC_SOP : PCC_DATA, data: pend_q};
            end else if (len_q == 16'd1) begin
              state_d = S_DROP;
              drop_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else begin
          state_d = S_IDLE;
          if (len_q < 16'd2 || fifo_count >= CNT_DEPTH) begin
            drop_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_data = '{code: frame_ok ? PCC_EOP : PCC_BADEOP, data: pend_q};
            good_d  = frame_ok;
            bad_d   = !frame_ok;
          end
        end
      end
      default: begin
        if (!dv_q) state_d = S_IDLE;
      end
    endcase

    // Every new frame starts from a clean accumulator, whichever state found the SFD.
    if (state_d == S_DATA && state_q != S_DATA) begin
      crc_d      = 32'hFFFF_FFFF;
      len_d      = '0;
      pend_vld_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_q      <= '0;
      dv_q       <= 1'b0;
      dv_p_q     <= 1'b0;
      state_q    <= S_IDLE;
      len_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rxd_q      <= gmii_rxd;
      dv_q       <= gmii_rx_dv;
      dv_p_q     <= dv_q;
      state_q    <= state_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovr_q      <= ovr_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  gmii_rx_fifo #(.ASZ(ASZ)) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_en && !reset),
    .wr_data_i (wr_data),
    .rd_srdy_o (rxg_srdy),
    .rd_drdy_i (rxg_drdy),
    .rd_data_o (rd_data),
    .count_o   (fifo_count)
  );

  assign rxg_data  = rd_data.data;
  assign rxg_code  = rd_data.code;
  assign stat_good = good_q;
  assign stat_bad  = bad_q;
  assign stat_drop = drop_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: frames built from Ethernet rules, beats
// checked against a frame-level expectation list plus literal spot values.
module tb_gmii_rx_deframer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       rxg_srdy;
  logic       rxg_drdy;
  logic [7:0] rxg_data;
  logic [1:0] rxg_code;
  logic       stat_good, stat_bad, stat_drop;

  always #5 clk = ~clk;

  gmii_rx_deframer #(.ASZ(4), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk        (clk),
    .reset      (reset),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .rxg_srdy   (rxg_srdy),
    .rxg_drdy   (rxg_drdy),
    .rxg_data   (rxg_data),
    .rxg_code   (rxg_code),
    .stat_good  (stat_good),
    .stat_bad   (stat_bad),
    .stat_drop  (stat_drop)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fr [0:1599];
  int         fr_len;
  logic [9:0] exp_mem [0:4095];
  int         exp_wr = 0;
  int         exp_rd = 0;
  logic [7:0] got_d [0:4095];
  logic [1:0] got_c [0:4095];
  int         got_total = 0;
  int         n_good = 0, n_bad = 0, n_drop = 0;
  int         t_b0 = 0, lat_seq = 0, lat_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle scoreboard: every accepted beat must be the next expected one.
  always @(negedge clk) begin
    if (!reset) begin
      n_good += int'(stat_good);
      n_bad  += int'(stat_bad);
      n_drop += int'(stat_drop);
      if (rxg_srdy && rxg_drdy) begin
        got_d[got_total % 4096] = rxg_data;
        got_c[got_total % 4096] = rxg_code;
        got_total++;
        if (lat_seq != lat_seen) begin
          lat_seen = lat_seq;
          chk("latency_b0", cyc - t_b0, 3);
        end
        if (exp_rd == exp_wr) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_beat: got code %0d data 0x%02h, expected no beat", rxg_code, rxg_data);
        end else begin
          chk("beat", int'({rxg_code, rxg_data}), int'(exp_mem[exp_rd % 4096]));
          exp_rd++;
        end
      end
    end
  end

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int len, input int flip_idx);
    logic [7:0]  hdr [0:11];
    logic [31:0] f;
    hdr = '{8'h01, 8'h00, 8'h5E, 8'h00, 8'h00, 8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    fr_len = len;
    for (int i = 0; i < len; i++) fr[i] = (i < 12) ? hdr[i] : 8'(i);
    if (len >= 16) begin
      f = fcs_of(len - 4);
      fr[len-4] = f[7:0];
      fr[len-3] = f[15:8];
      fr[len-2] = f[23:16];
      fr[len-1] = f[31:24];
    end
    if (flip_idx >= 0) fr[flip_idx] = fr[flip_idx] ^ 8'h01;
  endtask

  task automatic push(input logic [1:0] code, input logic [7:0] data);
    exp_mem[exp_wr % 4096] = {code, data};
    exp_wr++;
  endtask

  // Frame-level model: every byte after the SFD appears in order; the last
  // one is EOP only if the trailing FCS matches and the length is legal.
  task automatic expect_frame();
    logic [31:0] f;
    bit          ok;
    if (fr_len < 2) return;
    f  = fcs_of(fr_len - 4);
    ok = (fr[fr_len-4] == f[7:0]) && (fr[fr_len-3] == f[15:8]) &&
         (fr[fr_len-2] == f[23:16]) && (fr[fr_len-1] == f[31:24]) &&
         (fr_len >= 64) && (fr_len <= 1518);
    push(2'd1, fr[0]);
    for (int i = 1; i < fr_len - 1; i++) push(2'd0, fr[i]);
    push(ok ? 2'd2 : 2'd3, fr[fr_len-1]);
  endtask

  task automatic drive(input logic [7:0] d, input logic dv);
    @(posedge clk); #1;
    gmii_rxd   = d;
    gmii_rx_dv = dv;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0);
  endtask

  task automatic send_frame(input int bad_pre, input int rst_at, input bit arm_lat);
    for (int i = 0; i < 7; i++) drive((i == bad_pre) ? 8'h54 : 8'h55, 1'b1);
    drive(8'hD5, 1'b1);
    for (int i = 0; i < fr_len; i++) begin
      drive(fr[i], 1'b1);
      if (i == 0 && arm_lat) begin
        t_b0 = cyc;
        lat_seq++;
      end
      if (rst_at >= 0) reset = (i == rst_at) || (i == rst_at + 1);
    end
    drive(8'h00, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_rd != exp_wr || rxg_srdy) && k < 400) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk(name, int'(k < 400), 1);
  endtask

  int base, g0, b0, d0;

  task automatic snap();
    base = got_total;
    g0   = n_good;
    b0   = n_bad;
    d0   = n_drop;
  endtask

  initial begin
    reset = 1'b1; gmii_rxd = 8'h00; gmii_rx_dv = 1'b0; rxg_drdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_srdy", int'(rxg_srdy), 0);
    chk("rst_data", int'(rxg_data), 0);
    chk("rst_code", int'(rxg_code), 0);
    chk("rst_stats", int'({stat_good, stat_bad, stat_drop}), 0);
    @(posedge clk); #1; reset = 1'b0;
    idle(4);

    // Good 64-byte frame with latency check.
    snap(); build_frame(64, -1); expect_frame();
    send_frame(-1, -1, 1'b1); idle(12); wait_drain("drain_good");
    chk("good_beats", got_total - base, 64);
    chk("good_b0", int'(got_d[base]), 8'h01);
    chk("good_b1", int'(got_d[base+1]), 8'h00);
    chk("good_b2", int'(got_d[base+2]), 8'h5E);
    chk("good_b3", int'(got_d[base+3]), 8'h00);
    chk("good_b4", int'(got_d[base+4]), 8'h00);
    chk("good_b5", int'(got_d[base+5]), 8'h01);
    chk("good_sop", int'(got_c[base]), 1);
    chk("good_eop", int'(got_c[base+63]), 2);
    chk("good_stat", (n_good - g0) * 100 + (n_bad - b0) * 10 + (n_drop - d0), 100);

    // Corrupted byte 20.
    snap(); build_frame(64, 20); expect_frame();
    send_frame(-1, -1, 1'b0); idle(12); wait_drain("drain_crc");
    chk("crc_beats", got_total - base, 64);
    chk("crc_badeop", int'(got_c[base+63]), 3);
    chk("crc_stat", (n_good - g0) * 100 + (n_bad - b0) * 10 + (n_drop - d0), 10);

    // Bad preamble byte, then a clean frame.
    snap(); build_frame(64, -1);
    send_frame(3, -1, 1'b0); idle(12); wait_drain("drain_pre");
    chk("pre_beats", got_total - base, 0);
    chk("pre_stat", (n_good - g0) * 100 + (n_bad - b0) * 10 + (n_drop - d0), 1);
    snap(); expect_frame();
    send_frame(-1, -1, 1'b0); idle(12); wait_drain("drain_after_pre");
    chk("after_pre_beats", got_total - base, 64);
    chk("after_pre_stat", n_good - g0, 1);

    // Consumer stalled: 15 bytes fit, last slot holds BADEOP.
    rxg_drdy = 1'b0;
    snap(); build_frame(64, -1);
    push(2'd1, fr[0]);
    for (int i = 1; i < 15; i++) push(2'd0, fr[i]);
    push(2'd3, fr[63]);
    send_frame(-1, -1, 1'b0); idle(12);
    @(negedge clk);
    chk("full_stat", (n_good - g0) * 100 + (n_bad - b0) * 10 + (n_drop - d0), 10);
    chk("full_head", int'({rxg_srdy, rxg_code, rxg_data}), 11'h501);
    d0 = n_drop;
    send_frame(-1, -1, 1'b0); idle(12);
    chk("full_drop", n_drop - d0, 1);
    chk("full_head2", int'({rxg_srdy, rxg_code, rxg_data}), 11'h501);
    rxg_drdy = 1'b1;
    wait_drain("drain_full");
    chk("full_beats", got_total - base, 16);
    chk("full_last", int'({got_c[base+15], got_d[base+15]}), int'({2'd3, fr[63]}));

    // 1-byte frame, then a 40-byte frame below the minimum length.
    snap(); build_frame(1, -1);
    send_frame(-1, -1, 1'b0); idle(12); wait_drain("drain_one");
    chk("one_beats", got_total - base, 0);
    chk("one_stat", (n_good - g0) * 100 + (n_bad - b0) * 10 + (n_drop - d0), 1);
    snap(); build_frame(40, -1); expect_frame();
    send_frame(-1, -1, 1'b0); idle(12); wait_drain("drain_short");
    chk("short_beats", got_total - base, 40);
    chk("short_badeop", int'(got_c[base+39]), 3);
    chk("short_stat", n_bad - b0, 1);

    // Reset at byte 30: bytes 0..26 have already been delivered.
    snap(); build_frame(64, -1);
    push(2'd1, fr[0]);
    for (int i = 1; i < 27; i++) push(2'd0, fr[i]);
    send_frame(-1, 30, 1'b0); idle(12);
    @(negedge clk);
    chk("rst_mid_srdy", int'(rxg_srdy), 0);
    chk("rst_mid_beats", got_total - base, 27);
    snap(); build_frame(64, -1); expect_frame();
    send_frame(-1, -1, 1'b0); idle(12); wait_drain("drain_post_rst");
    chk("post_rst_beats", got_total - base, 64);
    chk("post_rst_eop", int'(got_c[base+63]), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500us");
    $fatal(1);
  end

endmodule
